// File: rtl/la_rle_expander_if.sv
// Stream bundle between the logic analyzer, the RLE expander and the sample consumer.
// The slave modport is the expander's view; the master modport is the environment's view.
interface la_rle_expander_if #(
    parameter int pSIG_W = 24,
    parameter int pRC_W  = 8
);
    logic [pRC_W+pSIG_W-1:0] s_tdata;
    logic                    s_tvalid;
    logic                    s_tlast;
    logic                    s_tready;
    logic [pSIG_W-1:0]       o_sample;
    logic                    o_valid;
    logic                    o_ready;
    logic                    o_ovf;
    logic                    o_last;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, o_ready,
        output s_tready, o_sample, o_valid, o_ovf, o_last
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, o_ready,
        input  s_tready, o_sample, o_valid, o_ovf, o_last
    );
endinterface

// File: rtl/la_rle_expander.sv
// Run-length expander for logic-analyzer trace words.
// Each word {rc, sample} is replayed as rc consecutive output samples.
// rc == 0 is an overflow marker: it emits nothing and flags the next sample.
module la_rle_expander #(
    parameter int pSIG_W = 24,
    parameter int pRC_W  = 8
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  enable,
    la_rle_expander_if.slave      bus,
    output logic [31:0]           sample_cnt,
    output logic [15:0]           ovf_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [pRC_W-1:0]    r_rem;
    logic [pRC_W-1:0]    w_rem_nxt;
    logic [pSIG_W-1:0]   r_sample;
    logic                r_tlast;
    logic                r_ovf_pend;

    logic [pRC_W-1:0]    w_rc;
    logic [pSIG_W-1:0]   w_smp;
    logic                w_ready;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_load;
    logic                w_marker;
    logic                w_rem_one;

    assign w_rc      = bus.s_tdata[pRC_W+pSIG_W-1 -: pRC_W];
    assign w_smp     = bus.s_tdata[pSIG_W-1:0];
    assign w_rem_one = (r_rem == pRC_W'(1));

    // Ready is combinational so the next word is taken on the cycle the last
    // sample of the current one leaves: no bubble between words. Gated by reset
    // so the analyzer sees ready low for the whole reset window.
    assign w_ready    = axi_reset_n & enable &
                        ((r_state == IDLE) | ((r_state == EXPAND) & w_rem_one & bus.o_ready));
    assign w_in_fire  = bus.s_tvalid & w_ready;
    assign w_load     = w_in_fire & (w_rc != '0);
    assign w_marker   = w_in_fire & (w_rc == '0);
    assign w_out_fire = (r_state == EXPAND) & bus.o_ready;

    // Next state and remaining count: load on a new word, count down per delivery.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = EXPAND;
                    w_rem_nxt   = w_rc;
                end
            end
            EXPAND: begin
                if (w_out_fire) begin
                    if (w_load) begin
                        w_rem_nxt = w_rc;
                    end else if (w_rem_one) begin
                        w_state_nxt = IDLE;
                        w_rem_nxt   = '0;
                    end else begin
                        w_rem_nxt = r_rem - pRC_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_rem_nxt   = '0;
            end
        endcase
    end

    // State and remaining-count registers; enable low is a synchronous soft clear.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else if (!enable) begin
            r_state <= IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Sample and tlast of the word being expanded; only a non-zero word loads them.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_sample <= '0;
            r_tlast  <= 1'b0;
        end else if (!enable) begin
            r_tlast  <= 1'b0;
        end else if (w_load) begin
            r_sample <= w_smp;
            r_tlast  <= bus.s_tlast;
        end
    end

    // Overflow pending: set by a marker, cleared once the flagged sample leaves.
    // Markers are only accepted in IDLE or on a final delivery, so any delivery
    // while pending is the first sample of the following word; a marker arriving
    // with that delivery must win.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_ovf_pend <= 1'b0;
        end else if (!enable) begin
            r_ovf_pend <= 1'b0;
        end else if (w_marker) begin
            r_ovf_pend <= 1'b1;
        end else if (w_out_fire) begin
            r_ovf_pend <= 1'b0;
        end
    end

    // Delivered-sample counter, free-running modulo 2^32.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            sample_cnt <= '0;
        end else if (!enable) begin
            sample_cnt <= '0;
        end else if (w_out_fire) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end

    // Overflow-marker counter, sticks at all-ones.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            ovf_cnt <= '0;
        end else if (!enable) begin
            ovf_cnt <= '0;
        end else if (w_marker && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    assign bus.s_tready = w_ready;
    assign bus.o_valid  = (r_state == EXPAND);
    assign bus.o_sample = r_sample;
    assign bus.o_ovf    = (r_state == EXPAND) & r_ovf_pend;
    assign bus.o_last   = (r_state == EXPAND) & w_rem_one & r_tlast;

endmodule
